pwm_fade_controller: RTL

- Sequencer that drives the duty_cycle and enable inputs of the team's 8-bit PWM core (9-bit duty, bit 8 = 100 %).
- Accepts fade requests (target duty, step size) over a valid/ready handshake.
- Ramps the duty toward the target by the step once every RATE PWM periods.
- Duty changes only at period boundaries, so the PWM output never glitches mid-period.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_period_tick.sv | 43 ++++
 rtl/pwm_fade_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: default widths, the
// full-on duty code, the controller state encoding and the target clamp.
package pwm_pkg;

    localparam int PWM_CNT_W  = 8;
    localparam int PWM_DUTY_W = PWM_CNT_W + 1;
    localparam int DUTY_FULL  = 1 << PWM_CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } fade_state_t;

    // Targets above full-on carry no extra meaning for the PWM core, so cap them.
    function automatic int unsigned clamp_duty(input int unsigned target,
                                               input int unsigned full);
        int unsigned r;
        r = (target > full) ? full : target;
        return r;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period counter (kept in lockstep with the PWM core counter) plus the
// ramp-rate prescaler. Produces the period-boundary and rate ticks.
module pwm_period_tick #(
    parameter int CNT_W = 8,
    parameter int RATE  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clr_rate,
    output logic o_boundary_tick,
    output logic o_rate_tick
);

    localparam logic [7:0] RATE_LAST = 8'(RATE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_rate;

    assign o_boundary_tick = i_enable && (r_cnt == '1);
    assign o_rate_tick     = o_boundary_tick && (r_rate == RATE_LAST);

    // Free-running period counter; resets and enables exactly like the PWM core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counts boundaries between ramp steps; request acceptance restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rate <= '0;
        end else if (i_clr_rate || o_rate_tick) begin
            r_rate <= '0;
        end else if (o_boundary_tick) begin
            r_rate <= r_rate + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_fade_controller.sv
// Fade sequencer for the 8-bit PWM core: accepts (target, step) requests and
// ramps duty_cycle toward the target one step per RATE PWM periods, updating
// only on period wrap edges. Define PWM_FADE_ABORT_EN to add the abort input.
module pwm_fade_controller
    import pwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W,
    parameter int DUTY_W = PWM_DUTY_W,
    parameter int RATE   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DUTY_W-1:0] req_target,
    input  logic [CNT_W-1:0]  req_step,
`ifdef PWM_FADE_ABORT_EN
    input  logic              abort,
`endif
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              pwm_enable,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FULL = 1 << CNT_W;

    fade_state_t       r_state;
    fade_state_t       w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] r_target;
    logic [CNT_W-1:0]  r_step;
    logic              w_accept;
    logic              w_boundary_tick;
    logic              w_rate_tick;

    // One ramp step toward tgt, done one bit wider so neither direction wraps;
    // the result saturates at tgt, and a zero step jumps straight there.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt,
                                                      input logic [CNT_W-1:0]  stp);
        logic [DUTY_W:0] c;
        logic [DUTY_W:0] t;
        logic [DUTY_W:0] s;
        logic [DUTY_W:0] n;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = (DUTY_W + 1)'(stp);
        if (stp == '0) begin
            n = t;
        end else if (c < t) begin
            n = c + s;
            if (n >= t) n = t;
        end else if ((c - t) <= s) begin
            n = t;
        end else begin
            n = c - s;
        end
        return n[DUTY_W-1:0];
    endfunction

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_RAMP);
    assign done       = (r_state == ST_DONE);
    assign pwm_enable = enable;
    assign duty_cycle = r_duty;

    pwm_period_tick #(
        .CNT_W (CNT_W),
        .RATE  (RATE)
    ) u_tick (
        .clk             (clk),
        .reset           (reset),
        .i_enable        (enable),
        .i_clr_rate      (w_accept),
        .o_boundary_tick (w_boundary_tick),
        .o_rate_tick     (w_rate_tick)
    );

    // State and duty registers; duty only moves on rate ticks, which sit on wrap edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    // Request capture; the target is clamped to full-on as it is latched.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_target <= DUTY_W'(clamp_duty(32'(req_target), FULL));
            r_step   <= req_step;
        end
    end

    // Next-state and next-duty; abort (when built in) beats a coincident rate tick.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
`ifdef PWM_FADE_ABORT_EN
                if (abort) w_state_nxt = ST_IDLE; else
`endif
                if (w_rate_tick) begin
                    w_duty_nxt = step_toward(r_duty, r_target, r_step);
                    if (w_duty_nxt == r_target) w_state_nxt = ST_DONE;
                end else if (enable && (r_duty == r_target)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
